onchip_mem_arbiter: RTL and testbench
=====================================

# onchip_mem_arbiter

Round-robin arbiter that shares one single-port 8192 x 32 on-chip RAM (1-cycle read latency: registered address, unregistered q) between NUM_REQ Avalon-MM masters, typically one per core in the multi-core platform. Each master gets a pipelined read/write slave port with waitrequest and readdatavalid. The arbiter drives the RAM's address, byteenable, chipselect, write, writedata and clken, and returns read data to the master that issued the read.

## Interface
- NUM_REQ, 3: number of requesters, 2..8.
- ADDR_W, 13: word address width (8192 words).
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_address  in  NUM_REQ*ADDR_W  per-requester word address, requester i in slice i.
- req_byteenable  in  NUM_REQ*DATA_W/8  per-requester byte enables.
- req_read  in  NUM_REQ  read request.
- req_write  in  NUM_REQ  write request; read and write both high is illegal and is treated as write.
- req_writedata  in  NUM_REQ*DATA_W  write data.
- req_waitrequest  out  NUM_REQ  high means the request was not accepted this cycle.
- req_readdata  out  DATA_W  shared read-data bus; qualified per requester by readdatavalid.
- req_readdatavalid  out  NUM_REQ  one-hot, one cycle per accepted read.
- mem_hold  in  1  freeze request (maps to RAM reset_req).
- mem_address  out  ADDR_W,  mem_byteenable  out  DATA_W/8,  mem_writedata  out  DATA_W: RAM port A.
- mem_chipselect  out  1,  mem_write  out  1,  mem_clken  out  1: RAM controls.
- mem_readdata  in  DATA_W  RAM q, valid one cycle after the read address is presented.
- grant_count  out  NUM_REQ*16  per-requester accepted-transfer counters, saturating.

## Operation
- FSM states:
  - RESET: entered while reset is high. No grants are issued. Exits to IDLE on the first cycle with reset low.
  - IDLE: no request pending.
  - SERVE: one transfer is granted this cycle.
  - HOLD: mem_hold is high.
- FSM transitions:
  - Any state goes to HOLD when mem_hold=1. HOLD returns to IDLE when mem_hold=0.
  - IDLE and SERVE each go to SERVE if any request is active, otherwise to IDLE.
- Arbitration:
  - Combinational, one winner per cycle, chosen among active requests (req_read|req_write).
  - Search starts at index rr_ptr and wraps modulo NUM_REQ.
  - rr_ptr register takes the value (winner+1) mod NUM_REQ on every accepted transfer. It is unchanged when there is no grant.
- Acceptance:
  - Winner's waitrequest is 0. All other requesters' waitrequest is 1.
  - Memory outputs are muxed from the winner in the same cycle: mem_chipselect=1, mem_write=req_write[winner].
  - With no winner, mem_chipselect=0, mem_write=0, and address/data hold their last values.
- Read return:
  - rd_owner (one-hot) register records the winner of an accepted read.
  - Next cycle: req_readdatavalid=rd_owner and req_readdata=mem_readdata.
  - Accepted writes produce no readdatavalid.
- mem_clken = ~mem_hold & ~reset. In HOLD, all waitrequest=1 and no new grants are issued.
- grant_count[i] increments on each accepted transfer of requester i and saturates at 0xFFFF.

## Timing
- Reset values:
  - req_waitrequest all 1, req_readdatavalid 0, req_readdata 0.
  - mem_chipselect 0, mem_write 0, mem_address 0.
  - rr_ptr 0, rd_owner 0, grant_count 0, state RESET.
- Read latency:
  - Read accepted in cycle T returns data and readdatavalid in T+1.
  - Back-to-back reads pipeline at 1 transfer/cycle.
- Write: completes in its accept cycle.
- Read after write to the same address from any requester in T+1 returns the new data.
- Fairness: with all NUM_REQ requesters continuously active, each is granted exactly once per NUM_REQ cycles. Worst-case wait is NUM_REQ-1 cycles.
- Hold:
  - mem_hold rising in cycle T blocks grants from T.
  - A read accepted in T-1 still returns its readdatavalid in T.
  - Because mem_clken=0, RAM q holds the T-1 result.
- Reset mid-read: a read accepted in the cycle before reset produces no readdatavalid; rd_owner is cleared.

## Structure
- Package onchip_mem_arb_pkg holds:
  - state enum {RESET, IDLE, SERVE, HOLD};
  - CNT_W=16;
  - function rr_pick(req_vec, ptr) returning the one-hot winner.
- Sub-module rr_arbiter: combinational pick plus the rr_ptr register. Reused by later bus arbiters.
- Top level holds the FSM, datapath muxes, rd_owner pipeline and counters.

## Test plan
- Reset then idle → all waitrequest=1 during reset. After reset, with no requests, mem_chipselect=0 and grant_count=0.
- Requester 1 writes 0xDEADBEEF to 0x0010 with byteenable 0xF, then reads 0x0010 → readdatavalid[1] one cycle after accept with readdata 0xDEADBEEF. Valid never asserts for requesters 0 or 2.
- All 3 requesters issue continuous reads to 0x0000/0x0001/0x0002 → grant order 0,1,2,0,1,2. Each readdatavalid returns its own address's data; grant_count increments by 1 per 3 cycles each.
- Byteenable 0x2 write of 0x0000AB00 over 0xFFFFFFFF at 0x1FFF → read returns 0xFFFFABFF (top address; no wrap).
- mem_hold high for 4 cycles during contention → mem_clken=0, all waitrequest=1, no grants. The pending read accepted before hold returns its data. Round-robin resumes at rr_ptr unchanged.
- Reset asserted the cycle after requester 2 read accept → no readdatavalid. State RESET, rr_ptr=0, grant_count=0.

Source files
------------

// File: rtl/onchip_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// onchip_mem_arb_pkg
// Shared types, constants and the round-robin pick helper used by the
// on-chip memory arbiter and by the bus arbiters that reuse rr_arbiter.
//
// Contents:
//   arb_state_e  - arbiter FSM states (RESET, IDLE, SERVE, HOLD)
//   CNT_W        - width of each per-requester grant counter
//   MAX_REQ      - largest requester count the pick helper supports
//   PTR_W        - width of a requester index / round-robin pointer
//   rr_pick()    - one-hot round-robin winner starting at a pointer
// ---------------------------------------------------------------------------
package onchip_mem_arb_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    IDLE  = 2'd1,
    SERVE = 2'd2,
    HOLD  = 2'd3
  } arb_state_e;

  localparam int CNT_W   = 16;
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // Scans n requesters starting at ptr and wrapping modulo n; the first
  // active one wins. Only the low n bits of req_vec take part. The wrap is a
  // conditional subtract so no divider is inferred for non-power-of-2 n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req_vec,
    input logic [PTR_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int                 idx;
    logic [PTR_W-1:0]   sel;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      sel = idx[PTR_W-1:0];
      if ((k < n) && (idx < MAX_REQ) && !found && req_vec[sel]) begin
        pick[sel] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick with a registered rotating pointer. The
// pointer moves to the slot after the winner on every grant and stays put
// on cycles without a grant.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset (pointer back to 0)
//   enable       in   when low no grant is issued and the pointer holds
//   req[N]       in   active requests
//   grant[N]     out  one-hot winner (all zero when none)
//   grant_valid  out  a grant is issued this cycle
// ---------------------------------------------------------------------------
module rr_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [MAX_REQ-1:0] req_pad;
  logic [MAX_REQ-1:0] pick;

  // Widen the request vector to the helper's fixed width; masking here
  // means a disabled arbiter produces no grant and no pointer movement.
  always_comb begin
    req_pad = '0;
    if (enable) req_pad[N-1:0] = req;
  end

  assign pick        = rr_pick(req_pad, rr_ptr, N);
  assign grant       = pick[N-1:0];
  assign grant_valid = |pick;

  // Encode the one-hot winner so the pointer can be advanced past it.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) grant_idx = PTR_W'(i);
    end
  end

  // Pointer update: next search starts just after the latest winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      if (grant_idx == PTR_W'(N - 1)) rr_ptr <= '0;
      else                            rr_ptr <= grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares one single-port on-chip RAM (registered address, unregistered q,
// one-cycle read latency) between NUM_REQ pipelined Avalon-MM masters with
// round-robin fairness. Read data returns on a shared bus qualified by a
// one-hot readdatavalid the cycle after the read is accepted.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_address/byteenable/read/write/writedata
//                           per-requester request fields, requester i in slice i
//   req_waitrequest[N]      1 = not accepted this cycle
//   req_readdata            shared read-data bus
//   req_readdatavalid[N]    one-hot, one pulse per accepted read
//   mem_hold                freeze request; blocks grants and stops RAM clock enable
//   mem_address/byteenable/writedata/chipselect/write/clken
//                           RAM port A
//   mem_readdata            RAM q
//   grant_count             per-requester saturating accepted-transfer counters
// ---------------------------------------------------------------------------
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_byteenable,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [DATA_W-1:0]             req_readdata,
  output logic [NUM_REQ-1:0]            req_readdatavalid,
  input  logic                          mem_hold,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W/8-1:0]           mem_byteenable,
  output logic [DATA_W-1:0]             mem_writedata,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic                          mem_clken,
  input  logic [DATA_W-1:0]             mem_readdata,
  output logic [NUM_REQ*CNT_W-1:0]      grant_count
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e          state_q;
  arb_state_e          state_next;
  logic                grant_en;
  logic [NUM_REQ-1:0]  active;
  logic [NUM_REQ-1:0]  grant;
  logic                grant_valid;

  logic [ADDR_W-1:0]   win_addr;
  logic [BE_W-1:0]     win_be;
  logic [DATA_W-1:0]   win_data;
  logic                win_write;

  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [NUM_REQ-1:0]  rd_owner;
  logic [NUM_REQ-1:0]  rd_owner_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REQ];

  assign active = req_read | req_write;

  // Grants only outside reset, outside a hold request, and not in the
  // first cycle after reset release (state still RESET).
  assign grant_en = ~reset & ~mem_hold & (state_q != RESET);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .enable      (grant_en),
    .req         (active),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET;
    else       state_q <= state_next;
  end

  // Next-state logic; a hold request overrides every other transition.
  always_comb begin
    state_next = state_q;
    if (mem_hold) begin
      state_next = HOLD;
    end else begin
      case (state_q)
        RESET:       state_next = IDLE;
        IDLE, SERVE: state_next = (|active) ? SERVE : IDLE;
        HOLD:        state_next = IDLE;
        default:     state_next = IDLE;
      endcase
    end
  end

  // One-hot mux of the winner's request fields. Read+write together is
  // taken as a write because win_write comes from req_write alone.
  always_comb begin
    win_addr  = '0;
    win_be    = '0;
    win_data  = '0;
    win_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr  = req_address[i*ADDR_W +: ADDR_W];
        win_be    = req_byteenable[i*BE_W +: BE_W];
        win_data  = req_writedata[i*DATA_W +: DATA_W];
        win_write = req_write[i];
      end
    end
  end

  // Remember the last granted address/byteenable/data so the RAM port
  // sits still on idle cycles instead of toggling back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (grant_valid) begin
      addr_q  <= win_addr;
      be_q    <= win_be;
      wdata_q <= win_data;
    end
  end

  assign mem_address    = grant_valid ? win_addr : addr_q;
  assign mem_byteenable = grant_valid ? win_be   : be_q;
  assign mem_writedata  = grant_valid ? win_data : wdata_q;
  assign mem_chipselect = grant_valid;
  assign mem_write      = grant_valid & win_write;
  assign mem_clken      = ~mem_hold & ~reset;

  assign req_waitrequest = ~grant;

  // Track who owns the read in flight so its data is steered back to the
  // right master next cycle.
  assign rd_owner_d = (grant_valid && !win_write) ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) rd_owner <= '0;
    else       rd_owner <= rd_owner_d;
  end

  // A read accepted just before reset must not surface while reset is
  // high, so the valid is masked combinationally as well.
  assign req_readdatavalid = reset ? '0 : rd_owner;
  assign req_readdata      = (|req_readdatavalid) ? mem_readdata : '0;

  // Per-requester accepted-transfer counters, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Flatten the counter array onto the packed output bus.
  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_count[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Directed bench for onchip_mem_arbiter with three requesters and a
// behavioural 8192 x 32 RAM (registered address, unregistered q, clken,
// byte enables). Inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;
  import onchip_mem_arb_pkg::*;

  localparam int NR = 3;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic                clk;
  logic                reset;
  logic [NR*AW-1:0]    req_address;
  logic [NR*BW-1:0]    req_byteenable;
  logic [NR-1:0]       req_read;
  logic [NR-1:0]       req_write;
  logic [NR*DW-1:0]    req_writedata;
  logic [NR-1:0]       req_waitrequest;
  logic [DW-1:0]       req_readdata;
  logic [NR-1:0]       req_readdatavalid;
  logic                mem_hold;
  logic [AW-1:0]       mem_address;
  logic [BW-1:0]       mem_byteenable;
  logic [DW-1:0]       mem_writedata;
  logic                mem_chipselect;
  logic                mem_write;
  logic                mem_clken;
  logic [DW-1:0]       mem_readdata;
  logic [NR*CNT_W-1:0] grant_count;

  logic [DW-1:0] ram [0:8191];
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] pat [NR];

  int total = 0;
  int bad   = 0;

  onchip_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_address       (req_address),
    .req_byteenable    (req_byteenable),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_writedata     (req_writedata),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .mem_hold          (mem_hold),
    .mem_address       (mem_address),
    .mem_byteenable    (mem_byteenable),
    .mem_writedata     (mem_writedata),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_clken         (mem_clken),
    .mem_readdata      (mem_readdata),
    .grant_count       (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model; reset reloads the fixed contents the directed steps read.
  always @(posedge clk) begin
    if (reset) begin
      ram[0]        <= 32'h1111_1111;
      ram[1]        <= 32'h2222_2222;
      ram[2]        <= 32'h3333_3333;
      ram[13'h1FFF] <= 32'hFFFF_FFFF;
    end
    if (mem_clken) begin
      ram_addr_q <= mem_address;
      if (mem_chipselect && mem_write) begin
        for (int b = 0; b < BW; b++) begin
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
      end
    end
  end

  assign mem_readdata = ram[ram_addr_q];

  task automatic applyStimulus(input int idx, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [BW-1:0] be,
                               input logic [DW-1:0] data);
    req_read[idx]                = rd;
    req_write[idx]               = wr;
    req_address[idx*AW +: AW]    = addr;
    req_byteenable[idx*BW +: BW] = be;
    req_writedata[idx*DW +: DW]  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int i);
    return {16'h0, grant_count[i*CNT_W +: CNT_W]};
  endfunction

  initial begin
    logic [2:0] exp_w;
    logic [2:0] exp_v;
    pat[0] = 32'h1111_1111;
    pat[1] = 32'h2222_2222;
    pat[2] = 32'h3333_3333;

    reset          = 1'b1;
    mem_hold       = 1'b0;
    req_address    = '0;
    req_byteenable = '0;
    req_read       = '0;
    req_write      = '0;
    req_writedata  = '0;

    // Reset with a live request: nothing may be granted.
    applyStimulus(0, 1'b1, 1'b0, 13'h0, 4'hF, 32'h0);
    repeat (2) tick();
    @(negedge clk);
    checkOutput("rst_wait",  {29'b0, req_waitrequest},   32'h7);
    checkOutput("rst_rdv",   {29'b0, req_readdatavalid}, 32'h0);
    checkOutput("rst_rdata", req_readdata,               32'h0);
    checkOutput("rst_cs",    {31'b0, mem_chipselect},    32'h0);
    checkOutput("rst_wr",    {31'b0, mem_write},         32'h0);
    checkOutput("rst_addr",  {19'b0, mem_address},       32'h0);
    checkOutput("rst_clken", {31'b0, mem_clken},         32'h0);
    checkOutput("rst_state", {30'b0, dut.state_q},       {30'b0, RESET});
    tick();

    // First cycle after release: still RESET, idle bus.
    reset = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("rel_state", {30'b0, dut.state_q},    {30'b0, RESET});
    checkOutput("rel_clken", {31'b0, mem_clken},      32'h1);
    checkOutput("rel_cnt",   grant_count[31:0],       32'h0);
    tick();
    @(negedge clk);
    checkOutput("idle_state", {30'b0, dut.state_q},   {30'b0, IDLE});
    checkOutput("idle_cs",    {31'b0, mem_chipselect}, 32'h0);
    tick();

    // Requester 1 writes then reads back 0x0010.
    applyStimulus(1, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("w1_wait",  {29'b0, req_waitrequest}, 32'h5);
    checkOutput("w1_cs",    {31'b0, mem_chipselect},  32'h1);
    checkOutput("w1_wr",    {31'b0, mem_write},       32'h1);
    checkOutput("w1_addr",  {19'b0, mem_address},     32'h0010);
    checkOutput("w1_wdata", mem_writedata,            32'hDEAD_BEEF);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("r1_wait", {29'b0, req_waitrequest}, 32'h5);
    checkOutput("r1_wr",   {31'b0, mem_write},       32'h0);
    checkOutput("w1_rdv",  {29'b0, req_readdatavalid}, 32'h0);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("r1_rdv",   {29'b0, req_readdatavalid}, 32'h2);
    checkOutput("r1_rdata", req_readdata,               32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    checkOutput("r1_rdv_off", {29'b0, req_readdatavalid}, 32'h0);
    checkOutput("r1_cnt0",    cnt(0), 32'h0);
    checkOutput("r1_cnt1",    cnt(1), 32'h2);
    checkOutput("r1_cnt2",    cnt(2), 32'h0);
    tick();

    // Byte-lane write at the top address, then read back.
    applyStimulus(0, 1'b0, 1'b1, 13'h1FFF, 4'h2, 32'h0000_AB00);
    @(negedge clk);
    checkOutput("be_wait", {29'b0, req_waitrequest}, 32'h6);
    checkOutput("be_be",   {28'b0, mem_byteenable},  32'h2);
    checkOutput("be_addr", {19'b0, mem_address},     32'h1FFF);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("be_rd_wait", {29'b0, req_waitrequest}, 32'h6);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("be_rdv",       {29'b0, req_readdatavalid}, 32'h1);
    checkOutput("be_rdata",     req_readdata,               32'hFFFF_ABFF);
    checkOutput("be_idle_cs",   {31'b0, mem_chipselect},    32'h0);
    checkOutput("be_addr_hold", {19'b0, mem_address},       32'h1FFF);
    checkOutput("be_ptr",       {29'b0, dut.u_rr.rr_ptr},   32'h1);
    tick();

    // Requester 2 read accepted, reset the following cycle.
    applyStimulus(2, 1'b1, 1'b0, 13'h0002, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("mr_wait", {29'b0, req_waitrequest}, 32'h3);
    tick();
    applyStimulus(2, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mr_rdv", {29'b0, req_readdatavalid}, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("mr_rdv2",  {29'b0, req_readdatavalid}, 32'h0);
    checkOutput("mr_owner", {29'b0, dut.rd_owner},      32'h0);
    checkOutput("mr_ptr",   {29'b0, dut.u_rr.rr_ptr},   32'h0);
    tick();

    // Release reset with all three requesters reading their own address.
    reset = 1'b0;
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 1'b0, AW'(i), 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("rr_state0", {30'b0, dut.state_q},    {30'b0, RESET});
    checkOutput("rr_wait0",  {29'b0, req_waitrequest}, 32'h7);
    checkOutput("rr_cnt0",   cnt(0) | cnt(1) | cnt(2), 32'h0);
    tick();

    // Six cycles of contention: grants 0,1,2,0,1,2 with data one behind.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_w = ~(3'b001 << (c % 3));
      checkOutput("rr_grant", {29'b0, req_waitrequest}, {29'b0, exp_w});
      if (c == 0) begin
        checkOutput("rr_rdv_first", {29'b0, req_readdatavalid}, 32'h0);
      end else begin
        exp_v = 3'b001 << ((c - 1) % 3);
        checkOutput("rr_rdv",   {29'b0, req_readdatavalid}, {29'b0, exp_v});
        checkOutput("rr_rdata", req_readdata, pat[(c - 1) % 3]);
      end
      tick();
    end

    // Seventh cycle: requester 0 again; each count is 2.
    @(negedge clk);
    checkOutput("c6_wait",  {29'b0, req_waitrequest},   32'h6);
    checkOutput("c6_rdv",   {29'b0, req_readdatavalid}, 32'h4);
    checkOutput("c6_rdata", req_readdata,               32'h3333_3333);
    checkOutput("c6_cnt0",  cnt(0), 32'h2);
    checkOutput("c6_cnt1",  cnt(1), 32'h2);
    checkOutput("c6_cnt2",  cnt(2), 32'h2);
    tick();

    // Hold for four cycles under contention.
    mem_hold = 1'b1;
    @(negedge clk);
    checkOutput("h_wait",  {29'b0, req_waitrequest},   32'h7);
    checkOutput("h_clken", {31'b0, mem_clken},         32'h0);
    checkOutput("h_cs",    {31'b0, mem_chipselect},    32'h0);
    checkOutput("h_rdv",   {29'b0, req_readdatavalid}, 32'h1);
    checkOutput("h_rdata", req_readdata,               32'h1111_1111);
    tick();
    @(negedge clk);
    checkOutput("h2_wait",  {29'b0, req_waitrequest},   32'h7);
    checkOutput("h2_rdv",   {29'b0, req_readdatavalid}, 32'h0);
    checkOutput("h2_state", {30'b0, dut.state_q},       {30'b0, HOLD});
    checkOutput("h2_q",     mem_readdata,               32'h1111_1111);
    repeat (3) tick();

    // Hold released: round robin resumes at requester 1.
    mem_hold = 1'b0;
    @(negedge clk);
    checkOutput("hr_wait",  {29'b0, req_waitrequest}, 32'h5);
    checkOutput("hr_clken", {31'b0, mem_clken},       32'h1);
    checkOutput("hr_ptr",   {29'b0, dut.u_rr.rr_ptr}, 32'h1);
    tick();
    @(negedge clk);
    checkOutput("hr2_wait",  {29'b0, req_waitrequest},   32'h3);
    checkOutput("hr2_rdv",   {29'b0, req_readdatavalid}, 32'h2);
    checkOutput("hr2_rdata", req_readdata,               32'h2222_2222);
    checkOutput("hr2_cnt0",  cnt(0), 32'h3);
    checkOutput("hr2_cnt1",  cnt(1), 32'h3);
    checkOutput("hr2_cnt2",  cnt(2), 32'h2);
    tick();

    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
